// File: rtl/speed_ctrl_if.sv
// Bus between the speed regulator and its environment: encoder pins, loop
// controls, and the duty command / status going to the PWM stage.
interface speed_ctrl_if;
  logic       EN;
  logic       ENC_A;
  logic       ENC_B;
  logic [7:0] TARGET;
  logic [7:0] DUTY;
  logic       DUTY_VALID;
  logic [7:0] SPEED;
  logic       ENC_ERR;

  // master drives loop controls and encoder pins, slave is the regulator
  modport master (
    output EN, ENC_A, ENC_B, TARGET,
    input  DUTY, DUTY_VALID, SPEED, ENC_ERR
  );

  modport slave (
    input  EN, ENC_A, ENC_B, TARGET,
    output DUTY, DUTY_VALID, SPEED, ENC_ERR
  );
endinterface

// File: rtl/speed_ctrl.sv
// Closed-loop speed regulator: counts quadrature edges over a fixed window,
// runs one PI update per window and issues an 8-bit duty command.
module speed_ctrl #(
  parameter int WIN_CYCLES = 50000,
  parameter int KP         = 16,
  parameter int KI         = 1,
  parameter int SHIFT      = 4,
  parameter int INT_LIM    = 4095
) (
  input logic         CLK,
  input logic         RST,
  speed_ctrl_if.slave bus
);

  localparam int WW = $clog2(WIN_CYCLES);

  localparam logic signed [16:0] LIM_P = 17'(INT_LIM);
  localparam logic signed [16:0] LIM_N = 17'(-INT_LIM);
  localparam logic signed [25:0] KP_S  = 26'(KP);
  localparam logic signed [25:0] KI_S  = 26'(KI);

  typedef enum logic [1:0] {S_SAMPLE, S_ERR, S_INTEG, S_OUT} state_t;

  state_t state_q, state_d;

  // encoder front end
  logic [1:0] a_sync, b_sync;
  logic       a_prev, b_prev;
  logic       a_chg, b_chg;
  logic       enc_edge, enc_ill;

  // measurement
  logic [WW-1:0] win_cnt;
  logic          win_end;
  logic [7:0]    edge_cnt, edge_inc, speed_q;
  logic          enc_err_q;

  // control datapath
  logic               ld_err, ld_int, ld_out;
  logic signed [8:0]  err_q;
  logic signed [15:0] integ_q, integ_clamp;
  logic signed [16:0] integ_sum;
  logic               integ_hold;
  logic signed [25:0] err_x, integ_x, u_sum, u_shift;
  logic [7:0]         duty_q, duty_next;
  logic               dv_q;

  // Synchronise the asynchronous encoder pins and keep one history sample.
  // Deliberately unreset so the history never disagrees with the pins after
  // RST, which would otherwise show up as a spurious edge or error.
  always_ff @(posedge CLK) begin
    a_sync <= {a_sync[0], bus.ENC_A};
    b_sync <= {b_sync[0], bus.ENC_B};
    a_prev <= a_sync[1];
    b_prev <= b_sync[1];
  end

  assign a_chg    = a_sync[1] ^ a_prev;
  assign b_chg    = b_sync[1] ^ b_prev;
  assign enc_edge = a_chg ^ b_chg;
  assign enc_ill  = a_chg & b_chg;

  // Free-running sampling window, never stalled by EN or the FSM.
  always_ff @(posedge CLK) begin
    if (RST)          win_cnt <= '0;
    else if (win_end) win_cnt <= '0;
    else              win_cnt <= win_cnt + WW'(1);
  end

  assign win_end  = (win_cnt == WW'(WIN_CYCLES - 1));
  assign edge_inc = (enc_edge && edge_cnt != 8'hFF) ? edge_cnt + 8'd1 : edge_cnt;

  // Edge counter; the count including any wrap-cycle edge becomes SPEED.
  always_ff @(posedge CLK) begin
    if (RST) begin
      edge_cnt <= '0;
      speed_q  <= '0;
    end else if (win_end) begin
      speed_q  <= edge_inc;
      edge_cnt <= '0;
    end else begin
      edge_cnt <= edge_inc;
    end
  end

  // Sticky illegal-transition flag, only RST clears it.
  always_ff @(posedge CLK) begin
    if (RST)          enc_err_q <= 1'b0;
    else if (enc_ill) enc_err_q <= 1'b1;
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_SAMPLE;
    else     state_q <= state_d;
  end

  // FSM next state: one pass ERR -> INTEG -> OUT after every window end.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SAMPLE: if (win_end) state_d = S_ERR;
      S_ERR:    state_d = S_INTEG;
      S_INTEG:  state_d = S_OUT;
      S_OUT:    state_d = S_SAMPLE;
      default:  state_d = S_SAMPLE;
    endcase
  end

  // FSM outputs: load strobes for the PI datapath.
  always_comb begin
    ld_err = 1'b0;
    ld_int = 1'b0;
    ld_out = 1'b0;
    case (state_q)
      S_ERR:   ld_err = 1'b1;
      S_INTEG: ld_int = 1'b1;
      S_OUT:   ld_out = 1'b1;
      default: ;
    endcase
  end

  // Integrator candidate, clamped, plus anti-windup against the current duty.
  always_comb begin
    integ_sum = {integ_q[15], integ_q} + {{8{err_q[8]}}, err_q};
    if (integ_sum > LIM_P)      integ_clamp = 16'(INT_LIM);
    else if (integ_sum < LIM_N) integ_clamp = 16'(-INT_LIM);
    else                        integ_clamp = integ_sum[15:0];
    integ_hold = (duty_q == 8'hFF && err_q > 9'sd0) ||
                 (duty_q == 8'd0  && err_q < 9'sd0);
  end

  // PI output, 26-bit so worst-case integ*KI cannot overflow, then saturate.
  always_comb begin
    err_x   = {{17{err_q[8]}}, err_q};
    integ_x = {{10{integ_q[15]}}, integ_q};
    u_sum   = err_x * KP_S + integ_x * KI_S;
    u_shift = u_sum >>> SHIFT;
    if (u_shift < 26'sd0)        duty_next = 8'd0;
    else if (u_shift > 26'sd255) duty_next = 8'd255;
    else                         duty_next = u_shift[7:0];
  end

  // PI registers; EN low zeroes duty and integrator every cycle but the
  // FSM keeps cycling so DUTY_VALID still marks each window.
  always_ff @(posedge CLK) begin
    if (RST) begin
      err_q   <= '0;
      integ_q <= '0;
      duty_q  <= '0;
      dv_q    <= 1'b0;
    end else begin
      dv_q <= ld_out;
      if (ld_err) err_q <= $signed({1'b0, bus.TARGET}) - $signed({1'b0, speed_q});
      if (!bus.EN)                   integ_q <= '0;
      else if (ld_int && !integ_hold) integ_q <= integ_clamp;
      if (!bus.EN)     duty_q <= '0;
      else if (ld_out) duty_q <= duty_next;
    end
  end

  assign bus.DUTY       = duty_q;
  assign bus.DUTY_VALID = dv_q;
  assign bus.SPEED      = speed_q;
  assign bus.ENC_ERR    = enc_err_q;

endmodule

// File: tb/tb_speed_ctrl.sv
// Bench for speed_ctrl: two instances (P-only and I-only) share stimulus and
// are checked every cycle against a per-window PI reference model.
module tb_speed_ctrl;
  localparam int WIN = 1000;
  localparam int SH  = 4;
  localparam int LIM = 4095;
  localparam int NW  = 43;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  speed_ctrl_if bp();
  speed_ctrl_if bi();

  speed_ctrl #(.WIN_CYCLES(WIN), .KP(16), .KI(0), .SHIFT(SH), .INT_LIM(LIM))
    dut_p (.CLK(CLK), .RST(RST), .bus(bp.slave));
  speed_ctrl #(.WIN_CYCLES(WIN), .KP(0), .KI(16), .SHIFT(SH), .INT_LIM(LIM))
    dut_i (.CLK(CLK), .RST(RST), .bus(bi.slave));

  int n_chk = 0;
  int n_err = 0;

  int kpv [2] = '{16, 0};
  int kiv [2] = '{0, 16};
  int m_duty [2];
  int m_integ[2];

  int pe [NW];
  int pt [NW];
  bit pen[NW];
  bit pill[NW];

  int pos = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // gray sequence 00,01,11,10 from a 2-bit position
  task automatic drive_enc(input int p);
    logic [1:0] pv;
    pv = p[1:0];
    bp.ENC_A = pv[1]; bp.ENC_B = pv[1] ^ pv[0];
    bi.ENC_A = pv[1]; bi.ENC_B = pv[1] ^ pv[0];
  endtask

  task automatic set_ctl(input bit en, input int t);
    bp.EN = en; bi.EN = en;
    bp.TARGET = 8'(t); bi.TARGET = 8'(t);
  endtask

  // reference: one PI update from the window's edge count
  task automatic win_update(input int d, input int e, input int t, input bit en);
    int spd, err, s, u;
    spd = (e > 255) ? 255 : e;
    err = t - spd;
    if (!en) begin
      m_integ[d] = 0;
      m_duty[d]  = 0;
    end else begin
      s = m_integ[d] + err;
      if (s > LIM)  s = LIM;
      if (s < -LIM) s = -LIM;
      if (!((m_duty[d] == 255 && err > 0) || (m_duty[d] == 0 && err < 0)))
        m_integ[d] = s;
      u = (err * kpv[d] + m_integ[d] * kiv[d]) >>> SH;
      m_duty[d] = (u < 0) ? 0 : ((u > 255) ? 255 : u);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " duty_p"},  int'(bp.DUTY),       0);
    chk({tag, " dv_p"},    int'(bp.DUTY_VALID), 0);
    chk({tag, " speed_p"}, int'(bp.SPEED),      0);
    chk({tag, " err_p"},   int'(bp.ENC_ERR),    0);
    chk({tag, " duty_i"},  int'(bi.DUTY),       0);
    chk({tag, " dv_i"},    int'(bi.DUTY_VALID), 0);
    chk({tag, " speed_i"}, int'(bi.SPEED),      0);
    chk({tag, " err_i"},   int'(bi.ENC_ERR),    0);
  endtask

  initial begin
    int  cyc, w, o, e_err, spd;
    bit  en_cur;

    // window plan: edges, target, enable, illegal flip
    for (int k = 0; k < NW; k++) begin
      pe[k] = 0; pt[k] = 10; pen[k] = 1'b1; pill[k] = 1'b0;
    end
    pt[0] = 100;
    pe[1] = 40;  pt[1] = 100;
    pe[2] = 300; pt[2] = 100;
    pe[3] = 40;  pt[3] = 100;
    pe[4] = 40;  pt[4] = 100; pen[4] = 1'b0;
    for (int k = 33; k < 37; k++) begin pe[k] = 10; pt[k] = 0; end
    pill[33] = 1'b1;
    for (int k = 37; k < NW; k++) begin
      pe[k]   = $urandom_range(0, 300);
      pt[k]   = $urandom_range(0, 255);
      pen[k]  = ($urandom_range(0, 3) != 0);
      pill[k] = ($urandom_range(0, 3) == 0);
    end

    set_ctl(1'b0, 0);
    drive_enc(pos);

    // reset state
    repeat (3) @(posedge CLK);
    #1 chk_zero("reset");

    // run briefly with edges and one illegal flip to dirty the state
    RST = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge CLK); #1;
      if (i == 20) begin pos = (pos + 2) & 3; drive_enc(pos); end
      else if (i > 40 && i < 140 && (i % 2) == 0) begin pos = (pos + 1) & 3; drive_enc(pos); end
    end
    chk("prerun enc_err_p", int'(bp.ENC_ERR), 1);
    chk("prerun enc_err_i", int'(bi.ENC_ERR), 1);
    chk("prerun speed_p",   int'(bp.SPEED),   0);

    // RST held 5 cycles mid-SAMPLE with the encoder still moving
    RST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      chk_zero("rst_hold");
      if (i < 2) begin pos = (pos + 1) & 3; drive_enc(pos); end
    end

    m_duty  = '{0, 0};
    m_integ = '{0, 0};
    e_err   = 0;
    en_cur  = pen[0];
    set_ctl(pen[0], pt[0]);
    RST = 1'b0;
    cyc = -1;

    while (cyc < NW * WIN + 5) begin
      @(posedge CLK); #1;
      cyc++;
      w = cyc / WIN;
      o = cyc % WIN;

      if (cyc >= WIN && o == 2) begin
        for (int d = 0; d < 2; d++) win_update(d, pe[w-1], pt[w-1], pen[w-1]);
        if (pill[w-1]) e_err = 1;
        spd = (pe[w-1] > 255) ? 255 : pe[w-1];
        chk("speed_p",   int'(bp.SPEED),   spd);
        chk("speed_i",   int'(bi.SPEED),   spd);
        chk("enc_err_p", int'(bp.ENC_ERR), e_err);
        chk("enc_err_i", int'(bi.ENC_ERR), e_err);
      end
      if (!en_cur) begin
        m_duty  = '{0, 0};
        m_integ = '{0, 0};
      end

      chk("duty_p", int'(bp.DUTY), m_duty[0]);
      chk("duty_i", int'(bi.DUTY), m_duty[1]);
      chk("dv_p", int'(bp.DUTY_VALID), (cyc >= WIN && o == 2) ? 1 : 0);
      chk("dv_i", int'(bi.DUTY_VALID), (cyc >= WIN && o == 2) ? 1 : 0);

      if (w < NW) begin
        if (o == 50 && pill[w]) begin pos = (pos + 2) & 3; drive_enc(pos); end
        if (o >= 100 && o < 100 + 2 * pe[w] && (o % 2) == 0) begin
          pos = (pos + 1) & 3; drive_enc(pos);
        end
        if (o == 900) begin
          set_ctl(pen[w], pt[w]);
          en_cur = pen[w];
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
